// File: rtl/register_file_mp.sv
// Multi-port byte-addressable register file with per-byte write priority, optional
// write-to-read bypass, a program-counter register and a pending-producer scoreboard.
module register_file_mp #(
    parameter int unsigned WORD        = 16,
    parameter int unsigned REGISTERS   = 8,
    parameter int unsigned READ_PORTS  = 2,
    parameter int unsigned WRITE_PORTS = 2,
    parameter int unsigned PC          = 7,
    parameter int unsigned PC_STEP     = 2,
    parameter int unsigned BYPASS      = 1
) (
    input  logic                         clk_i,
    input  logic                         arst_ni,
    input  logic                         wrEn_i   [WRITE_PORTS],
    input  logic [WORD/8-1:0]            wrMode_i [WRITE_PORTS],
    input  logic [$clog2(REGISTERS)-1:0] wrAddr_i [WRITE_PORTS],
    input  logic [WORD-1:0]              data_i   [WRITE_PORTS],
    input  logic [$clog2(REGISTERS)-1:0] rdAddr_i [READ_PORTS],
    output logic [WORD-1:0]              data_o   [READ_PORTS],
    output logic                         rdBusy_o [READ_PORTS],
    input  logic [1:0]                   pcMode_i,
    input  logic [WORD-1:0]              pc_i,
    output logic [WORD-1:0]              pc_o,
    input  logic                         rsvEn_i,
    input  logic [$clog2(REGISTERS)-1:0] rsvAddr_i,
    output logic [REGISTERS-1:0]         busy_o
);

    localparam int unsigned BYTES = WORD / 8;
    localparam int unsigned AW    = $clog2(REGISTERS);
    localparam logic [AW-1:0] PC_IDX = AW'(PC);

    logic [WORD-1:0]      r_regs [REGISTERS];
    logic [REGISTERS-1:0] r_busy;

    logic [WORD-1:0]      w_merged [REGISTERS];
    logic [REGISTERS-1:0] w_hit;
    logic [WORD-1:0]      w_pc_next;
    logic [REGISTERS-1:0] w_busy_next;

    // Ports are applied in ascending order so the highest-index port wins each byte.
    always_comb begin
        for (int i = 0; i < REGISTERS; i++) begin
            w_merged[i] = r_regs[i];
            w_hit[i]    = 1'b0;
            for (int p = 0; p < WRITE_PORTS; p++) begin
                if (wrEn_i[p] && (wrAddr_i[p] == AW'(i))) begin
                    for (int b = 0; b < BYTES; b++) begin
                        if (wrMode_i[p][b]) begin
                            w_merged[i][b*8 +: 8] = data_i[p][b*8 +: 8];
                            w_hit[i]              = 1'b1;
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        w_pc_next = r_regs[PC_IDX];
        if (pcMode_i == 2'b10) begin
            w_pc_next = pc_i;
        end else if (w_hit[PC_IDX]) begin
            w_pc_next = w_merged[PC_IDX];
        end else if (pcMode_i == 2'b01) begin
            w_pc_next = r_regs[PC_IDX] + WORD'(PC_STEP);
        end
    end

    // A reservation in the same cycle as a write marks a new producer, so it wins.
    always_comb begin
        w_busy_next = r_busy & ~w_hit;
        if (rsvEn_i) begin
            w_busy_next[rsvAddr_i] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            for (int i = 0; i < REGISTERS; i++) begin
                r_regs[i] <= '0;
            end
            r_busy <= '0;
        end else begin
            for (int i = 0; i < REGISTERS; i++) begin
                if (AW'(i) == PC_IDX) begin
                    r_regs[i] <= w_pc_next;
                end else begin
                    r_regs[i] <= w_merged[i];
                end
            end
            r_busy <= w_busy_next;
        end
    end

    always_comb begin
        for (int r = 0; r < READ_PORTS; r++) begin
            if (BYPASS != 0) begin
                data_o[r]   = w_merged[rdAddr_i[r]];
                rdBusy_o[r] = r_busy[rdAddr_i[r]] && !w_hit[rdAddr_i[r]];
            end else begin
                data_o[r]   = r_regs[rdAddr_i[r]];
                rdBusy_o[r] = r_busy[rdAddr_i[r]];
            end
        end
    end

    assign pc_o   = r_regs[PC_IDX];
    assign busy_o = r_busy;

endmodule

// File: tb/tb_register_file_mp.sv
// Directed vector table plus reset sequence and random stress against a reference model,
// driving a bypassing and a non-bypassing instance with identical stimulus.
module tb_register_file_mp;

    logic        clk;
    logic        arst_n;
    logic        wr_en   [2];
    logic [1:0]  wr_mode [2];
    logic [2:0]  wr_addr [2];
    logic [15:0] wr_data [2];
    logic [2:0]  rd_addr [2];
    logic [15:0] rd_data_b [2];
    logic [15:0] rd_data_n [2];
    logic        rd_busy_b [2];
    logic        rd_busy_n [2];
    logic [1:0]  pc_mode;
    logic [15:0] pc_in;
    logic [15:0] pc_b, pc_n;
    logic        rsv_en;
    logic [2:0]  rsv_addr;
    logic [7:0]  busy_b, busy_n;

    int checks   = 0;
    int failures = 0;

    register_file_mp #(.BYPASS(1)) u_byp (
        .clk_i(clk), .arst_ni(arst_n), .wrEn_i(wr_en), .wrMode_i(wr_mode),
        .wrAddr_i(wr_addr), .data_i(wr_data), .rdAddr_i(rd_addr), .data_o(rd_data_b),
        .rdBusy_o(rd_busy_b), .pcMode_i(pc_mode), .pc_i(pc_in), .pc_o(pc_b),
        .rsvEn_i(rsv_en), .rsvAddr_i(rsv_addr), .busy_o(busy_b)
    );

    register_file_mp #(.BYPASS(0)) u_nob (
        .clk_i(clk), .arst_ni(arst_n), .wrEn_i(wr_en), .wrMode_i(wr_mode),
        .wrAddr_i(wr_addr), .data_i(wr_data), .rdAddr_i(rd_addr), .data_o(rd_data_n),
        .rdBusy_o(rd_busy_n), .pcMode_i(pc_mode), .pc_i(pc_in), .pc_o(pc_n),
        .rsvEn_i(rsv_en), .rsvAddr_i(rsv_addr), .busy_o(busy_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        e0; logic [1:0] m0; logic [2:0] a0; logic [15:0] d0;
        logic        e1; logic [1:0] m1; logic [2:0] a1; logic [15:0] d1;
        logic [1:0]  pcm; logic [15:0] pci;
        logic        rsv; logic [2:0] ra;
        logic [2:0]  rd;
        logic [15:0] x_byp; logic [15:0] x_now; logic x_rb; logic x_rn;
        logic [15:0] x_after; logic [15:0] x_pc; logic [7:0] x_busy;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs [NV];

    logic [15:0] m_regs [8];
    logic [7:0]  m_busy;
    logic [15:0] m_merged [8];
    logic [7:0]  m_hit;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic idle();
        for (int p = 0; p < 2; p++) begin
            wr_en[p] = 1'b0; wr_mode[p] = 2'b00; wr_addr[p] = 3'd0; wr_data[p] = 16'h0;
        end
        pc_mode = 2'b00; pc_in = 16'h0; rsv_en = 1'b0; rsv_addr = 3'd0;
    endtask

    task automatic model_comb();
        for (int i = 0; i < 8; i++) begin
            m_merged[i] = m_regs[i];
            m_hit[i]    = 1'b0;
        end
        for (int p = 0; p < 2; p++) begin
            if (wr_en[p]) begin
                for (int b = 0; b < 2; b++) begin
                    if (wr_mode[p][b]) begin
                        m_merged[wr_addr[p]][b*8 +: 8] = wr_data[p][b*8 +: 8];
                        m_hit[wr_addr[p]] = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic model_step();
        logic [15:0] pcv;
        if (pc_mode == 2'b10)      pcv = pc_in;
        else if (m_hit[7])         pcv = m_merged[7];
        else if (pc_mode == 2'b01) pcv = m_regs[7] + 16'd2;
        else                       pcv = m_regs[7];
        for (int i = 0; i < 7; i++) m_regs[i] = m_merged[i];
        m_regs[7] = pcv;
        m_busy = m_busy & ~m_hit;
        if (rsv_en) m_busy[rsv_addr] = 1'b1;
    endtask

    initial begin
        vec_t v;
        vecs[0]  = '{1, 2'd3, 3'd2, 16'hAABB, 1, 2'd1, 3'd2, 16'h00CC, 2'd0, 16'h0, 0, 3'd0, 3'd2,
                     16'hAACC, 16'h0000, 0, 0, 16'hAACC, 16'h0000, 8'h00};
        vecs[1]  = '{1, 2'd2, 3'd2, 16'h5500, 0, 2'd0, 3'd0, 16'h0, 2'd0, 16'h0, 0, 3'd0, 3'd2,
                     16'h55CC, 16'hAACC, 0, 0, 16'h55CC, 16'h0000, 8'h00};
        vecs[2]  = '{1, 2'd3, 3'd1, 16'h0F0F, 0, 2'd0, 3'd0, 16'h0, 2'd0, 16'h0, 0, 3'd0, 3'd1,
                     16'h0F0F, 16'h0000, 0, 0, 16'h0F0F, 16'h0000, 8'h00};
        vecs[3]  = '{1, 2'd1, 3'd1, 16'h1234, 0, 2'd0, 3'd0, 16'h0, 2'd0, 16'h0, 0, 3'd0, 3'd1,
                     16'h0F34, 16'h0F0F, 0, 0, 16'h0F34, 16'h0000, 8'h00};
        vecs[4]  = '{1, 2'd3, 3'd7, 16'hFFFE, 0, 2'd0, 3'd0, 16'h0, 2'd0, 16'h0, 0, 3'd0, 3'd7,
                     16'hFFFE, 16'h0000, 0, 0, 16'hFFFE, 16'hFFFE, 8'h00};
        vecs[5]  = '{0, 2'd0, 3'd0, 16'h0, 0, 2'd0, 3'd0, 16'h0, 2'd1, 16'h0, 0, 3'd0, 3'd7,
                     16'hFFFE, 16'hFFFE, 0, 0, 16'h0000, 16'h0000, 8'h00};
        vecs[6]  = '{0, 2'd0, 3'd0, 16'h0, 1, 2'd3, 3'd7, 16'h2222, 2'd2, 16'h0100, 0, 3'd0, 3'd0,
                     16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0100, 8'h00};
        vecs[7]  = '{1, 2'd3, 3'd7, 16'h0040, 0, 2'd0, 3'd0, 16'h0, 2'd1, 16'h0, 0, 3'd0, 3'd2,
                     16'h55CC, 16'h55CC, 0, 0, 16'h55CC, 16'h0040, 8'h00};
        vecs[8]  = '{1, 2'd1, 3'd7, 16'h0077, 0, 2'd0, 3'd0, 16'h0, 2'd3, 16'h0, 0, 3'd0, 3'd3,
                     16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0077, 8'h00};
        vecs[9]  = '{0, 2'd0, 3'd0, 16'h0, 0, 2'd0, 3'd0, 16'h0, 2'd1, 16'h0, 0, 3'd0, 3'd3,
                     16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0079, 8'h00};
        vecs[10] = '{0, 2'd0, 3'd0, 16'h0, 0, 2'd0, 3'd0, 16'h0, 2'd0, 16'h0, 1, 3'd5, 3'd5,
                     16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0079, 8'h20};
        vecs[11] = '{0, 2'd0, 3'd0, 16'h0, 0, 2'd0, 3'd0, 16'h0, 2'd0, 16'h0, 0, 3'd0, 3'd5,
                     16'h0000, 16'h0000, 1, 1, 16'h0000, 16'h0079, 8'h20};
        vecs[12] = '{1, 2'd3, 3'd5, 16'hBEEF, 0, 2'd0, 3'd0, 16'h0, 2'd0, 16'h0, 0, 3'd0, 3'd5,
                     16'hBEEF, 16'h0000, 0, 1, 16'hBEEF, 16'h0079, 8'h00};
        vecs[13] = '{0, 2'd0, 3'd0, 16'h0, 1, 2'd1, 3'd5, 16'h1111, 2'd0, 16'h0, 1, 3'd5, 3'd5,
                     16'hBE11, 16'hBEEF, 0, 0, 16'hBE11, 16'h0079, 8'h20};
        vecs[14] = '{0, 2'd0, 3'd0, 16'h0, 0, 2'd0, 3'd0, 16'h0, 2'd0, 16'h0, 1, 3'd3, 3'd5,
                     16'hBE11, 16'hBE11, 1, 1, 16'hBE11, 16'h0079, 8'h28};
        vecs[15] = '{1, 2'd0, 3'd3, 16'hFFFF, 0, 2'd0, 3'd0, 16'h0, 2'd0, 16'h0, 0, 3'd0, 3'd3,
                     16'h0000, 16'h0000, 1, 1, 16'h0000, 16'h0079, 8'h28};
        vecs[16] = '{1, 2'd3, 3'd4, 16'h1357, 1, 2'd2, 3'd6, 16'h2468, 2'd0, 16'h0, 0, 3'd0, 3'd6,
                     16'h2400, 16'h0000, 0, 0, 16'h2400, 16'h0079, 8'h28};

        arst_n = 1'b0;
        idle();
        rd_addr[0] = 3'd0; rd_addr[1] = 3'd7;
        #3;
        chk("reset_pc", 32'(pc_b), 32'h0);
        chk("reset_busy", 32'(busy_b), 32'h0);
        chk("reset_data", 32'(rd_data_n[0]), 32'h0);
        @(negedge clk);
        arst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            v = vecs[i];
            @(negedge clk);
            wr_en[0] = v.e0; wr_mode[0] = v.m0; wr_addr[0] = v.a0; wr_data[0] = v.d0;
            wr_en[1] = v.e1; wr_mode[1] = v.m1; wr_addr[1] = v.a1; wr_data[1] = v.d1;
            pc_mode = v.pcm; pc_in = v.pci; rsv_en = v.rsv; rsv_addr = v.ra;
            rd_addr[0] = v.rd;
            #1;
            chk($sformatf("v%0d_bypass_data", i), 32'(rd_data_b[0]), 32'(v.x_byp));
            chk($sformatf("v%0d_stored_data", i), 32'(rd_data_n[0]), 32'(v.x_now));
            chk($sformatf("v%0d_rdbusy_byp", i), 32'(rd_busy_b[0]), 32'(v.x_rb));
            chk($sformatf("v%0d_rdbusy_nob", i), 32'(rd_busy_n[0]), 32'(v.x_rn));
            @(negedge clk);
            idle();
            #1;
            chk($sformatf("v%0d_after_data", i), 32'(rd_data_n[0]), 32'(v.x_after));
            chk($sformatf("v%0d_pc", i), 32'(pc_b), 32'(v.x_pc));
            chk($sformatf("v%0d_pc_nob", i), 32'(pc_n), 32'(v.x_pc));
            chk($sformatf("v%0d_busy", i), 32'(busy_b), 32'(v.x_busy));
        end

        // Asynchronous reset between clock edges
        @(negedge clk);
        wr_en[0] = 1'b1; wr_mode[0] = 2'b11; wr_addr[0] = 3'd3; wr_data[0] = 16'h1234;
        rd_addr[0] = 3'd3;
        @(negedge clk);
        idle();
        #1;
        chk("pre_reset_r3", 32'(rd_data_n[0]), 32'h1234);
        #1 arst_n = 1'b0;
        #1;
        chk("async_reset_r3", 32'(rd_data_n[0]), 32'h0);
        chk("async_reset_r3_byp", 32'(rd_data_b[0]), 32'h0);
        chk("async_reset_pc", 32'(pc_b), 32'h0);
        chk("async_reset_busy", 32'(busy_b), 32'h0);
        #1 arst_n = 1'b1;

        for (int i = 0; i < 8; i++) m_regs[i] = 16'h0;
        m_busy = 8'h0;

        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            for (int p = 0; p < 2; p++) begin
                wr_en[p]   = 1'($urandom_range(0, 1));
                wr_mode[p] = 2'($urandom_range(0, 3));
                wr_addr[p] = 3'($urandom_range(0, 7));
                wr_data[p] = 16'($urandom);
                rd_addr[p] = 3'($urandom_range(0, 7));
            end
            pc_mode  = 2'($urandom_range(0, 3));
            pc_in    = 16'($urandom);
            rsv_en   = ($urandom_range(0, 3) == 0);
            rsv_addr = 3'($urandom_range(0, 7));
            #1;
            model_comb();
            for (int r = 0; r < 2; r++) begin
                chk($sformatf("rnd%0d_byp_data%0d", c, r), 32'(rd_data_b[r]),
                    32'(m_merged[rd_addr[r]]));
                chk($sformatf("rnd%0d_nob_data%0d", c, r), 32'(rd_data_n[r]),
                    32'(m_regs[rd_addr[r]]));
                chk($sformatf("rnd%0d_byp_rdbusy%0d", c, r), 32'(rd_busy_b[r]),
                    32'(m_busy[rd_addr[r]] && !m_hit[rd_addr[r]]));
                chk($sformatf("rnd%0d_nob_rdbusy%0d", c, r), 32'(rd_busy_n[r]),
                    32'(m_busy[rd_addr[r]]));
            end
            chk($sformatf("rnd%0d_pc", c), 32'(pc_b), 32'(m_regs[7]));
            chk($sformatf("rnd%0d_pc_nob", c), 32'(pc_n), 32'(m_regs[7]));
            chk($sformatf("rnd%0d_busy", c), 32'(busy_b), 32'(m_busy));
            model_step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
